// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the 4-digit seven-segment scanner.
//   SEG_TABLE : nibble -> active-low segments {g,f,e,d,c,b,a}
//   SEG_OFF   : all segments dark
//   AN_OFF    : all anodes off (active-low)
//   state_t   : scanner FSM states
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Entry 0 is the rightmost element of the concatenation.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

endpackage

// File: rtl/seg7_scanner_hex_to_seg7.sv
// hex_to_seg7: combinational hex nibble to active-low seven-segment pattern.
//   nibble : in,  4 - hex value
//   seg    : out, 7 - {g,f,e,d,c,b,a}, active-low
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_scanner.sv
// seg7_scanner: time-multiplexed driver for a 4-digit common-anode display.
// Advances one digit per scan_tick, blanks all anodes for BLANK_CYCLES after
// each tick, and double-buffers display data so a frame is never mixed.
//   clk_in     : in,  1  - system clock
//   reset      : in,  1  - synchronous, active-high
//   scan_tick  : in,  1  - single-cycle digit-advance strobe
//   data_in    : in,  16 - four hex nibbles, [3:0] = digit 0 (rightmost)
//   dp_in      : in,  4  - decimal points, 1 = lit, bit i = digit i
//   load       : in,  1  - capture data_in/dp_in into pending buffer
//   an         : out, 4  - anodes, active-low
//   seg        : out, 7  - cathodes {g,f,e,d,c,b,a}, active-low
//   dp         : out, 1  - decimal-point cathode, active-low
//   frame_done : out, 1  - pulse when pending is committed to active
module seg7_scanner
    import seg7_pkg::*;
#(
    parameter int BLANK_CYCLES    = 1000,
    parameter bit LEAD_ZERO_BLANK = 1'b1
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        scan_tick,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int CW_RAW = $clog2(BLANK_CYCLES + 1);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam logic [CW-1:0] CNT_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    state_t        state_q, state_n;
    logic [1:0]    idx_q, idx_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [19:0]   pend_q, pend_n;
    logic [19:0]   act_q, act_n;
    logic [3:0]    an_n;
    logic [6:0]    seg_n;
    logic          dp_n;
    logic          wrap;

    logic [3:0][3:0] act_dig;
    logic [3:0]      act_dp;
    logic [3:0]      cur_nib;
    logic [6:0]      dec_seg;
    logic            lz_blank;

    // Buffers: load always refreshes pending; a wrap strobe copies the
    // post-load pending value so a same-cycle load lands in both buffers.
    always_comb begin
        wrap   = scan_tick && (idx_q == 2'd3);
        pend_n = load ? {dp_in, data_in} : pend_q;
        act_n  = wrap ? pend_n : act_q;
        idx_n  = scan_tick ? idx_q + 2'd1 : idx_q;
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        if (scan_tick) begin
            state_n = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
            cnt_n   = '0;
        end else if (state_q == BLANK) begin
            if (cnt_q == CNT_LAST) state_n = DRIVE;
            else                   cnt_n   = cnt_q + 1'b1;
        end
    end

    // Outputs are computed from next-state values so the registered pins
    // change exactly on DRIVE entry or while all anodes are off.
    always_comb begin
        act_dig  = act_n[15:0];
        act_dp   = act_n[19:16];
        cur_nib  = act_dig[idx_n];
        lz_blank = LEAD_ZERO_BLANK && (idx_n != 2'd0) &&
                   ((act_n[15:0] >> {idx_n, 2'b00}) == 16'h0);
    end

    hex_to_seg7 u_dec (
        .nibble (cur_nib),
        .seg    (dec_seg)
    );

    always_comb begin
        an_n  = AN_OFF;
        seg_n = SEG_OFF;
        dp_n  = 1'b1;
        if (state_n == DRIVE) begin
            an_n  = ~(4'b0001 << idx_n);
            seg_n = lz_blank ? SEG_OFF : dec_seg;
            dp_n  = ~act_dp[idx_n];
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q    <= OFF;
            idx_q      <= 2'd3;
            cnt_q      <= '0;
            pend_q     <= '0;
            act_q      <= '0;
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_n;
            idx_q      <= idx_n;
            cnt_q      <= cnt_n;
            pend_q     <= pend_n;
            act_q      <= act_n;
            an         <= an_n;
            seg        <= seg_n;
            dp         <= dp_n;
            frame_done <= wrap;
        end
    end

endmodule
